// File: rtl/iram_loadable.sv
// Runtime-loadable instruction store for the downsampling processor.
// Programs stream in through a valid/ready load port; fetch has 1- or 2-cycle latency.
module iram_loadable #(
   parameter int    DATA_W    = 8,
   parameter int    ADDR_W    = 8,
   parameter int    RD_LAT    = 1,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              FETCH,
   input  logic [ADDR_W-1:0] iAddr,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [ADDR_W:0]   load_len,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_valid,
   output logic              load_ready,
   output logic              load_done,
   output logic              busy
);
   // state  | meaning
   // S_IDLE | fetches accepted, waiting for load_start
   // S_LOAD | accepting load words, fetches dropped
   // S_DONE | one-cycle load_done pulse, fetches dropped
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   wptr;
   logic [ADDR_W:0]     remaining;
   logic [DATA_W-1:0]   mem [2**ADDR_W];
   logic                fetch_acc;
   logic                wr_en;

   assign fetch_acc = FETCH && (state == S_IDLE);
   assign wr_en     = (state == S_LOAD) && load_valid;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (load_start) state_nx = (load_len == '0) ? S_DONE : S_LOAD;
         S_LOAD:  if (load_valid && remaining == (ADDR_W+1)'(1)) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they are glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         wptr       <= '0;
         remaining  <= '0;
         load_ready <= 1'b0;
         load_done  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nx;
         load_ready <= (state_nx == S_LOAD);
         load_done  <= (state_nx == S_DONE);
         busy       <= (state_nx != S_IDLE);
         if (state == S_IDLE && load_start) begin
            wptr      <= load_base;
            remaining <= load_len;
         end else if (wr_en) begin
            wptr      <= wptr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
         end
      end
   end

   // Memory has no reset: a burst cut short by reset keeps what it wrote.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= load_data;
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic [DATA_W-1:0] rd_q;
         logic              rd_v;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_q        <= '0;
               rd_v        <= 1'b0;
               instr       <= '0;
               instr_valid <= 1'b0;
            end else begin
               rd_v        <= fetch_acc;
               if (fetch_acc) rd_q <= mem[iAddr];
               instr_valid <= rd_v;
               if (rd_v) instr <= rd_q;
            end
         end
      end else begin : g_lat1
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               instr       <= '0;
               instr_valid <= 1'b0;
            end else begin
               instr_valid <= fetch_acc;
               if (fetch_acc) instr <= mem[iAddr];
            end
         end
      end
   endgenerate
endmodule
